// File: rtl/bp_update_queue_if.sv
// bp_update_queue_if: resolution-side and predictor-side signals of the branch update queue
interface bp_update_queue_if #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 32
);
    logic                         res_valid_i;
    logic                         res_ready_o;
    logic [63:0]                  res_pc_i;
    logic                         res_taken_i;
    logic                         res_pred_taken_i;
    logic                         flush_i;
    logic                         upd_stall_i;
    logic                         update_valid_o;
    logic [63:0]                  update_pc_o;
    logic                         update_taken_o;
    logic [$clog2(DEPTH+1)-1:0]   count_o;
    logic [CNT_W-1:0]             mispredict_cnt_o;

    modport master (
        output res_valid_i, res_pc_i, res_taken_i, res_pred_taken_i, flush_i, upd_stall_i,
        input  res_ready_o, update_valid_o, update_pc_o, update_taken_o, count_o, mispredict_cnt_o
    );

    modport slave (
        input  res_valid_i, res_pc_i, res_taken_i, res_pred_taken_i, flush_i, upd_stall_i,
        output res_ready_o, update_valid_o, update_pc_o, update_taken_o, count_o, mispredict_cnt_o
    );
endinterface

// File: rtl/bp_update_queue.sv
// bp_update_queue: FIFO of resolved branch outcomes draining one per cycle into the predictor update port
module bp_update_queue #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 32
) (
    input logic              clk,
    input logic              rst_n,
    bp_update_queue_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [64:0]      mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [CW-1:0]    cnt;
    logic [CNT_W-1:0] mis;
    logic             ready;
    logic             valid;
    logic             push;
    logic             pop;

    assign ready = cnt != CW'(DEPTH);
    assign valid = (cnt != '0) && !bus.upd_stall_i;
    assign push  = bus.res_valid_i && ready && !bus.flush_i;
    assign pop   = valid && !bus.flush_i;

    assign bus.res_ready_o      = ready;
    assign bus.update_valid_o   = valid;
    assign bus.update_pc_o      = valid ? mem[rd_ptr][64:1] : '0;
    assign bus.update_taken_o   = valid ? mem[rd_ptr][0] : 1'b0;
    assign bus.count_o          = cnt;
    assign bus.mispredict_cnt_o = mis;

    // Entry storage needs no reset: reads are masked until occupancy covers the slot
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {bus.res_pc_i, bus.res_taken_i};
    end

    // Pointers and occupancy; flush wins over any same-cycle push or pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else if (bus.flush_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            cnt <= cnt + CW'(push) - CW'(pop);
        end
    end

    // Saturating count of accepted mispredicted branches, kept across flushes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) mis <= '0;
        else if (push && (bus.res_taken_i != bus.res_pred_taken_i) && (mis != '1)) mis <= mis + CNT_W'(1);
    end
endmodule

// File: tb/tb_bp_update_queue.sv
// tb_bp_update_queue: directed scoreboard bench for bp_update_queue
module tb_bp_update_queue;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int errors = 0;
    int checks = 0;
    logic [64:0] mq[$];
    longint unsigned mmis = 0;

    bp_update_queue_if #(.DEPTH(DEPTH), .CNT_W(32)) ifa ();
    bp_update_queue_if #(.DEPTH(DEPTH), .CNT_W(4))  ifb ();

    bp_update_queue #(.DEPTH(DEPTH), .CNT_W(32)) u_dut (.clk(clk), .rst_n(rst_n), .bus(ifa.slave));
    bp_update_queue #(.DEPTH(DEPTH), .CNT_W(4))  u_sat (.clk(clk), .rst_n(rst_n), .bus(ifb.slave));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [63:0] pc, input logic t, input logic p);
        ifa.res_valid_i      = v;
        ifa.res_pc_i         = pc;
        ifa.res_taken_i      = t;
        ifa.res_pred_taken_i = p;
    endtask

    // One cycle: compare outputs mid-cycle against the scoreboard, then advance it across the edge
    task automatic step();
        logic acc;
        logic pv;
        logic [64:0] head;
        @(negedge clk);
        acc = ifa.res_valid_i && (mq.size() != DEPTH) && !ifa.flush_i;
        pv  = (mq.size() != 0) && !ifa.upd_stall_i;
        head = (mq.size() != 0) ? mq[0] : 65'd0;
        chk("ready", 64'(ifa.res_ready_o), 64'(mq.size() != DEPTH));
        chk("valid", 64'(ifa.update_valid_o), 64'(pv));
        chk("count", 64'(ifa.count_o), 64'(mq.size()));
        chk("mispredict", 64'(ifa.mispredict_cnt_o), mmis);
        chk("upd_pc", ifa.update_pc_o, pv ? head[64:1] : 64'd0);
        chk("upd_taken", 64'(ifa.update_taken_o), pv ? 64'(head[0]) : 64'd0);
        if (ifa.flush_i) mq.delete();
        else begin
            if (pv) void'(mq.pop_front());
            if (acc) mq.push_back({ifa.res_pc_i, ifa.res_taken_i});
        end
        if (acc && (ifa.res_taken_i != ifa.res_pred_taken_i)) mmis++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(1'b0, 64'd0, 1'b0, 1'b0);
        ifa.flush_i = 1'b0;
        ifa.upd_stall_i = 1'b0;
        ifb.res_valid_i = 1'b0;
        ifb.res_pc_i = 64'd0;
        ifb.res_taken_i = 1'b0;
        ifb.res_pred_taken_i = 1'b0;
        ifb.flush_i = 1'b0;
        ifb.upd_stall_i = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_valid", 64'(ifa.update_valid_o), 64'd0);
        chk("rst_pc", ifa.update_pc_o, 64'd0);
        chk("rst_taken", 64'(ifa.update_taken_o), 64'd0);
        chk("rst_count", 64'(ifa.count_o), 64'd0);
        chk("rst_ready", 64'(ifa.res_ready_o), 64'd1);
        chk("rst_mis", 64'(ifa.mispredict_cnt_o), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // single entry round trip
        drive(1'b1, 64'h1000, 1'b1, 1'b1);
        step();
        chk("t1_count1", 64'(ifa.count_o), 64'd1);
        drive(1'b0, 64'd0, 1'b0, 1'b0);
        step();
        chk("t1_count0", 64'(ifa.count_o), 64'd0);
        step();

        // fill under stall, ninth push ignored, then drain in order
        ifa.upd_stall_i = 1'b1;
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, 64'h100 + 64'(i), i[0], i[0]);
            step();
        end
        chk("t2_full_count", 64'(ifa.count_o), 64'd8);
        chk("t2_full_ready", 64'(ifa.res_ready_o), 64'd0);
        drive(1'b0, 64'd0, 1'b0, 1'b0);
        ifa.upd_stall_i = 1'b0;
        for (int i = 0; i < 8; i++) step();
        chk("t2_drained", 64'(ifa.count_o), 64'd0);

        // full queue: no push on first pop cycle, push accepted on the next
        ifa.upd_stall_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 64'h200 + 64'(i), 1'b1, 1'b1);
            step();
        end
        ifa.upd_stall_i = 1'b0;
        drive(1'b1, 64'h2ff, 1'b0, 1'b0);
        step();
        chk("t3_count_a", 64'(ifa.count_o), 64'd7);
        step();
        chk("t3_count_b", 64'(ifa.count_o), 64'd7);
        drive(1'b0, 64'd0, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) step();
        chk("t3_drained", 64'(ifa.count_o), 64'd0);

        // streaming push/pop past the pointer wrap
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 64'h300 + 64'(i), ~i[1], ~i[1]);
            step();
            chk("t4_count", 64'(ifa.count_o), 64'd1);
        end
        drive(1'b0, 64'd0, 1'b0, 1'b0);
        step();

        // mispredicts then flush with a concurrent (dropped) push
        ifa.upd_stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 64'h400 + 64'(i), 1'b1, 1'b0);
            step();
        end
        ifa.upd_stall_i = 1'b0;
        ifa.flush_i = 1'b1;
        drive(1'b1, 64'h4ff, 1'b0, 1'b1);
        step();
        ifa.flush_i = 1'b0;
        drive(1'b0, 64'd0, 1'b0, 1'b0);
        chk("t5_count", 64'(ifa.count_o), 64'd0);
        chk("t5_mis", 64'(ifa.mispredict_cnt_o), 64'd3);
        step();
        chk("t5_valid_after", 64'(ifa.update_valid_o), 64'd0);

        // narrow counter saturates at 15
        ifb.res_valid_i = 1'b1;
        ifb.res_taken_i = 1'b1;
        ifb.res_pred_taken_i = 1'b0;
        for (int i = 0; i < 17; i++) begin
            ifb.res_pc_i = 64'h500 + 64'(i);
            @(posedge clk);
            #1;
            if (i == 13) chk("t6_mis14", 64'(ifb.mispredict_cnt_o), 64'd14);
            if (i == 14) chk("t6_mis15", 64'(ifb.mispredict_cnt_o), 64'd15);
        end
        ifb.res_valid_i = 1'b0;
        chk("t6_mis_sat", 64'(ifb.mispredict_cnt_o), 64'd15);
        chk("t6_count", 64'(ifb.count_o), 64'd1);

        // reset mid-drain clears outputs immediately
        ifa.upd_stall_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 64'h600 + 64'(i), 1'b0, 1'b1);
            step();
        end
        drive(1'b0, 64'd0, 1'b0, 1'b0);
        ifa.upd_stall_i = 1'b0;
        step();
        #1;
        rst_n = 1'b0;
        #1;
        chk("t7_valid", 64'(ifa.update_valid_o), 64'd0);
        chk("t7_pc", ifa.update_pc_o, 64'd0);
        chk("t7_taken", 64'(ifa.update_taken_o), 64'd0);
        chk("t7_count", 64'(ifa.count_o), 64'd0);
        chk("t7_ready", 64'(ifa.res_ready_o), 64'd1);
        chk("t7_mis", 64'(ifa.mispredict_cnt_o), 64'd0);
        chk("t7_sat_mis", 64'(ifb.mispredict_cnt_o), 64'd0);
        mq.delete();
        mmis = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/bp_update_queue.md
Name: bp_update_queue

Overview:
- Buffers resolved-branch outcomes from the execute/branch-resolution unit.
- Drains them, one per cycle, into the branch predictor's update port (update_valid/update_pc/update_taken).
- Decouples resolution bursts from predictor training, supports a predictor-side stall, and keeps a saturating mispredict statistic.
- Sits between branch resolution (upstream) and the predictor's training interface (downstream).

Parameters:
- DEPTH, 8: queue entries; power of two, >= 2.
- CNT_W, 32: width of the mispredict counter.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- res_valid_i  input  1  resolved branch presented.
- res_ready_o  output  1  queue can accept (not full).
- res_pc_i  input  64  PC of resolved branch.
- res_taken_i  input  1  actual direction.
- res_pred_taken_i  input  1  direction predicted at fetch.
- flush_i  input  1  discard all queued entries.
- upd_stall_i  input  1  predictor cannot accept an update this cycle.
- update_valid_o  output  1  update presented to predictor.
- update_pc_o  output  64  PC for predictor update.
- update_taken_o  output  1  actual direction for predictor update.
- count_o  output  $clog2(DEPTH+1)  current occupancy.
- mispredict_cnt_o  output  CNT_W  saturating count of accepted mispredicted branches.

Behaviour:
- Reset (async assert, sync release):
  - occupancy 0, read/write pointers 0, mispredict counter 0.
  - update_valid_o=0, update_pc_o=0, update_taken_o=0, count_o=0, res_ready_o=1.
  - Reset mid-operation discards all entries immediately.
- Push:
  - res_ready_o = (count != DEPTH), driven combinationally from registered state only, with no dependence on pop. When full, ready is low even if a pop occurs that cycle.
  - An entry {res_pc_i, res_taken_i} is written at the rising edge where res_valid_i && res_ready_o && !flush_i.
  - res_pred_taken_i is not stored.
- Pop / output:
  - update_valid_o = (count != 0) && !upd_stall_i.
  - update_pc_o / update_taken_o = head entry when update_valid_o=1, else 0.
  - Head is popped at the rising edge where update_valid_o=1 && !flush_i.
  - Exactly one update is presented per cycle; each entry is presented in exactly one valid cycle.
- Latency:
  - An entry pushed at edge E is visible on update outputs in the cycle after E at the earliest.
  - There is no same-cycle bypass from res_* to update_*.
- Ordering: strict FIFO; PC and taken bit travel together unchanged.
- Simultaneous push and pop (0 < count < DEPTH): both occur; count is unchanged; pointers each advance by one.
- Pointer wrap: read/write pointers are log2(DEPTH) bits and wrap modulo DEPTH naturally. Full/empty are derived from the occupancy counter, not from pointer comparison.
- Stall: while upd_stall_i=1, nothing is popped, the head is held, and pushes continue until full.
- Flush:
  - At an edge with flush_i=1, occupancy becomes 0 and pointers reset to 0.
  - Any same-cycle push is dropped.
  - Any same-cycle pop is not considered performed (update_valid_o is still combinationally 1 if entries exist; the predictor observing it is acceptable, but the entry is discarded).
  - mispredict counter is NOT cleared by flush.
- Mispredict counter:
  - Increments by 1 at each edge where a push is accepted and res_taken_i != res_pred_taken_i.
  - Saturates at all-ones; it does not wrap.
  - Pushes dropped by flush or full do not count.
- count_o: registered occupancy, range 0..DEPTH.

Test Plan:
- Reset, then push PC=0x1000 taken=1 pred=1 at edge 1 -> update_valid_o=1, update_pc_o=0x1000, update_taken_o=1 in cycle after edge 1 only; count_o returns 0; mispredict_cnt_o=0.
- upd_stall_i=1, push 8 entries PC=0x100..0x107 -> res_ready_o=0 at count_o=8, 9th push ignored; release stall -> updates emerge 0x100..0x107 on 8 consecutive cycles.
- Full queue with stall released and res_valid_i=1 held -> no push on the first pop cycle (ready low); push accepted next cycle; count_o goes 8->7->7.
- Continuous push/pop for 20 entries (count stays 1) -> output order matches input, verifying pointer wrap past DEPTH.
- 3 pushes with taken!=pred, then flush_i with a concurrent push -> count_o=0 next cycle, mispredict_cnt_o=3, update_valid_o=0 afterwards.
- CNT_W=4 build, 17 mispredicted pushes -> mispredict_cnt_o saturates at 15; assert rst_n low mid-drain -> all outputs 0 immediately.
